// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input.
// Ports: i_clock/i_reset (async, active-high), i_pwm (async input);
//        o_period/o_pulse/o_timeout qualified by the one-cycle o_valid strobe; o_level = synced input.
module pwm_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_pwm,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_pulse,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_level
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  // The synchroniser is cleared by reset, so s is meaningless until it has
  // refilled; WAIT_LOW ignores s for this many cycles after reset.
  localparam int FILL_MAX = SYNC_STAGES + 1;
  localparam int FW       = $clog2(FILL_MAX + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [FW-1:0]          fill;
  logic                   fill_done;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       hi;
  logic                   tmo;
  state_t                 state;
  state_t                 state_nxt;

  logic cnt_arm;
  logic cnt_inc;
  logic hi_load;
  logic res_load;
  logic res_timeout;

  assign s         = sync[SYNC_STAGES-1];
  assign rise      = s & ~s_d;
  assign fall      = ~s & s_d;
  assign fill_done = (fill == FW'(FILL_MAX));
  assign o_level   = s;

  // cnt is armed to 1 and only ever increments while measuring, so it reads
  // zero in HIGH/LOW exactly when 2^WIDTH cycles have elapsed since the
  // arming rise. Checking it ahead of rise lets the timeout win a tie.
  assign tmo = (cnt == '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= WAIT_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_arm     = 1'b0;
    cnt_inc     = 1'b0;
    hi_load     = 1'b0;
    res_load    = 1'b0;
    res_timeout = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (fill_done && !s) begin
          state_nxt = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          cnt_arm   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (tmo) begin
          res_load    = 1'b1;
          res_timeout = 1'b1;
          state_nxt   = WAIT_LOW;
        end else if (fall) begin
          hi_load   = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = LOW;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      LOW: begin
        if (tmo) begin
          res_load    = 1'b1;
          res_timeout = 1'b1;
          state_nxt   = WAIT_LOW;
        end else if (rise) begin
          // Report and re-arm on the same edge so no period is dropped.
          res_load  = 1'b1;
          cnt_arm   = 1'b1;
          state_nxt = HIGH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync <= '0;
      s_d  <= 1'b0;
      fill <= '0;
      cnt  <= '0;
      hi   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_pwm};
      s_d  <= s;
      if (!fill_done) begin
        fill <= fill + 1'b1;
      end
      if (cnt_arm) begin
        cnt <= WIDTH'(1);
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (hi_load) begin
        hi <= cnt;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      o_period  <= '0;
      o_pulse   <= '0;
    end else begin
      o_valid <= res_load;
      if (res_load) begin
        o_timeout <= res_timeout;
        o_period  <= res_timeout ? '0 : cnt;
        o_pulse   <= res_timeout ? '0 : hi;
      end
    end
  end

endmodule
